// File: rtl/free_ptr_queue_if.sv
// rtl/free_ptr_queue_if.sv - handshake bundle between the free pointer queue and its users
//
// Purpose: groups the pointer return/allocate signals of free_ptr_queue.
// Signals:
//   ptr_din        pointer returned to the queue (only the low PTR_W bits are stored)
//   FQ_wr          push ptr_din this cycle
//   FQ_rd          pop the head pointer this cycle
//   ptr_dout_s     show-ahead head pointer
//   ptr_fifo_empty queue holds no pointers
//   FQ_act         initial load finished
//   FQ_count       number of queued pointers
// Modports: master = ingress/egress user side, slave = queue side.
interface free_ptr_queue_if #(
   parameter int PTR_W = 10,
   parameter int CNT_W = 10,
   parameter int DIN_W = 16
);
   logic [DIN_W-1:0] ptr_din;
   logic             FQ_wr;
   logic             FQ_rd;
   logic [PTR_W-1:0] ptr_dout_s;
   logic             ptr_fifo_empty;
   logic             FQ_act;
   logic [CNT_W-1:0] FQ_count;

   modport master (
      output ptr_din, FQ_wr, FQ_rd,
      input  ptr_dout_s, ptr_fifo_empty, FQ_act, FQ_count
   );

   modport slave (
      input  ptr_din, FQ_wr, FQ_rd,
      output ptr_dout_s, ptr_fifo_empty, FQ_act, FQ_count
   );
endinterface

// File: rtl/free_ptr_queue.sv
// rtl/free_ptr_queue.sv - free cell pointer queue with self-load after reset
//
// Purpose: circular queue of free buffer-cell pointers. After reset it writes
// pointers 0..PTR_NUM-1 into itself, one per clock, then serves pops (allocate)
// and pushes (release) from the switch datapath.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, restarts the self-load
//   fq   free_ptr_queue_if.slave: ptr_din/FQ_wr/FQ_rd in,
//        ptr_dout_s/ptr_fifo_empty/FQ_act/FQ_count out
module free_ptr_queue #(
   parameter int PTR_NUM = 512,
   parameter int PTR_W   = 10
) (
   input  logic            clk,
   input  logic            rst,
   free_ptr_queue_if.slave fq
);
   localparam int IDX_W = $clog2(PTR_NUM);
   localparam int CNT_W = $clog2(PTR_NUM + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PTR_NUM);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PTR_NUM - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t           state;
   logic [PTR_W-1:0] mem [PTR_NUM];
   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             act;

   logic             do_pop;
   logic             do_push;
   logic             mem_we;
   logic [PTR_W-1:0] mem_wdata;
   logic             unused_din_hi;

   // Upper pointer bits are carried on the bus but never stored.
   assign unused_din_hi = ^fq.ptr_din[$bits(fq.ptr_din)-1:PTR_W];

   always_comb begin
      do_pop    = 1'b0;
      do_push   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = fq.ptr_din[PTR_W-1:0];
      if (state == ST_INIT) begin
         // Self-load: slot k receives pointer k, user strobes are ignored.
         mem_we    = !rst;
         mem_wdata = PTR_W'(tail);
      end else begin
         do_pop  = fq.FQ_rd && (count != '0);
         // A push at full is accepted only when a pop frees a slot in the same edge.
         do_push = fq.FQ_wr && ((count != CNT_FULL) || do_pop);
         mem_we  = do_push && !rst;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[tail] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         act   <= 1'b0;
      end else if (state == ST_INIT) begin
         tail  <= tail + 1'b1;
         count <= count + 1'b1;
         if (tail == IDX_LAST) begin
            state <= ST_RUN;
            act   <= 1'b1;
         end
      end else begin
         if (do_pop) begin
            head <= head + 1'b1;
         end
         if (do_push) begin
            tail <= tail + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Show-ahead head: a consumer samples it in the cycle it raises FQ_rd.
   assign fq.ptr_dout_s     = mem[head];
   assign fq.ptr_fifo_empty = (count == '0);
   assign fq.FQ_act         = act;
   assign fq.FQ_count       = count;
endmodule

// File: tb/tb_free_ptr_queue.sv
// tb/tb_free_ptr_queue.sv - self-checking bench for free_ptr_queue
module tb_free_ptr_queue;
   logic clk;
   logic rst;

   free_ptr_queue_if fq ();

   free_ptr_queue dut (
      .clk (clk),
      .rst (rst),
      .fq  (fq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: a queue of pointer values plus an init counter.
   int mq[$];
   int init_k = 0;
   bit m_act = 1'b0;

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
      end
   endfunction

   function automatic void model_step(input bit r, input bit rd, input bit wr, input logic [15:0] d);
      bit p;
      bit w;
      if (r) begin
         mq.delete();
         init_k = 0;
         m_act  = 1'b0;
      end else if (!m_act) begin
         mq.push_back(init_k);
         init_k++;
         if (init_k == 512) m_act = 1'b1;
      end else begin
         p = rd && (mq.size() > 0);
         w = wr && ((mq.size() < 512) || p);
         if (p) void'(mq.pop_front());
         if (w) mq.push_back(int'(d[9:0]));
      end
   endfunction

   function automatic void model_check();
      chk("model_count", 32'(fq.FQ_count), mq.size());
      chk("model_empty", 32'(fq.ptr_fifo_empty), 32'(mq.size() == 0));
      chk("model_act", 32'(fq.FQ_act), 32'(m_act));
      if (mq.size() > 0) chk("model_dout", 32'(fq.ptr_dout_s), mq[0]);
   endfunction

   task automatic cycle(input bit r, input bit rd, input bit wr, input logic [15:0] d);
      rst        = r;
      fq.FQ_rd   = rd;
      fq.FQ_wr   = wr;
      fq.ptr_din = d;
      @(posedge clk);
      model_step(r, rd, wr, d);
      #1;
      model_check();
   endtask

   typedef struct {
      int          reps;
      logic        r;
      logic        rd;
      logic        wr;
      logic [15:0] din;
      int          e_count;
      logic        e_empty;
      logic        e_act;
      logic        e_chk;
      logic [9:0]  e_dout;
   } vec_t;

   vec_t vecs[12];
   int   sq[$];
   int   pr_tab[4];
   logic [15:0] d;

   initial begin
      rst        = 1'b1;
      fq.FQ_rd   = 1'b0;
      fq.FQ_wr   = 1'b0;
      fq.ptr_din = 16'h0;

      vecs[0]  = '{1,   1'b1, 1'b0, 1'b0, 16'h0000, 0,   1'b1, 1'b0, 1'b0, 10'h000};
      vecs[1]  = '{1,   1'b0, 1'b0, 1'b0, 16'h0000, 1,   1'b0, 1'b0, 1'b1, 10'h000};
      vecs[2]  = '{510, 1'b0, 1'b1, 1'b1, 16'h0055, 511, 1'b0, 1'b0, 1'b1, 10'h000};
      vecs[3]  = '{1,   1'b0, 1'b0, 1'b0, 16'h0000, 512, 1'b0, 1'b1, 1'b1, 10'h000};
      vecs[4]  = '{1,   1'b0, 1'b0, 1'b1, 16'h03FF, 512, 1'b0, 1'b1, 1'b1, 10'h000};
      vecs[5]  = '{1,   1'b0, 1'b1, 1'b0, 16'h0000, 511, 1'b0, 1'b1, 1'b1, 10'h001};
      vecs[6]  = '{4,   1'b0, 1'b1, 1'b0, 16'h0000, 507, 1'b0, 1'b1, 1'b1, 10'h005};
      vecs[7]  = '{507, 1'b0, 1'b1, 1'b0, 16'h0000, 0,   1'b1, 1'b1, 1'b0, 10'h000};
      vecs[8]  = '{1,   1'b0, 1'b1, 1'b0, 16'h0000, 0,   1'b1, 1'b1, 1'b0, 10'h000};
      vecs[9]  = '{1,   1'b0, 1'b0, 1'b1, 16'hFC07, 1,   1'b0, 1'b1, 1'b1, 10'h007};
      vecs[10] = '{1,   1'b0, 1'b1, 1'b1, 16'h0155, 1,   1'b0, 1'b1, 1'b1, 10'h155};
      vecs[11] = '{1,   1'b1, 1'b0, 1'b0, 16'h0000, 0,   1'b1, 1'b0, 1'b0, 10'h000};

      for (int i = 0; i < 12; i++) begin
         for (int k = 0; k < vecs[i].reps; k++)
            cycle(vecs[i].r, vecs[i].rd, vecs[i].wr, vecs[i].din);
         chk($sformatf("vec%0d_count", i), 32'(fq.FQ_count), vecs[i].e_count);
         chk($sformatf("vec%0d_empty", i), 32'(fq.ptr_fifo_empty), 32'(vecs[i].e_empty));
         chk($sformatf("vec%0d_act", i), 32'(fq.FQ_act), 32'(vecs[i].e_act));
         if (vecs[i].e_chk)
            chk($sformatf("vec%0d_dout", i), 32'(fq.ptr_dout_s), 32'(vecs[i].e_dout));
      end

      // Self-load from reset, then drain in order.
      for (int i = 0; i < 511; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
      chk("init_act_early", 32'(fq.FQ_act), 0);
      cycle(1'b0, 1'b0, 1'b0, 16'h0);
      chk("init_act", 32'(fq.FQ_act), 1);
      chk("init_count", 32'(fq.FQ_count), 512);
      chk("init_dout", 32'(fq.ptr_dout_s), 0);
      for (int i = 0; i < 5; i++) begin
         chk("pop5_dout", 32'(fq.ptr_dout_s), i);
         cycle(1'b0, 1'b1, 1'b0, 16'h0);
      end
      chk("pop5_count", 32'(fq.FQ_count), 507);
      for (int i = 5; i < 512; i++) begin
         chk("popall_dout", 32'(fq.ptr_dout_s), i);
         cycle(1'b0, 1'b1, 1'b0, 16'h0);
      end
      chk("popall_count", 32'(fq.FQ_count), 0);
      chk("popall_empty", 32'(fq.ptr_fifo_empty), 1);
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      chk("underflow_count", 32'(fq.FQ_count), 0);
      cycle(1'b0, 1'b0, 1'b1, 16'hFC07);
      chk("push1_count", 32'(fq.FQ_count), 1);
      chk("push1_dout", 32'(fq.ptr_dout_s), 32'h007);
      chk("push1_empty", 32'(fq.ptr_fifo_empty), 0);
      cycle(1'b0, 1'b1, 1'b0, 16'h0);

      // Move head/tail near the top so the swap run wraps both.
      for (int i = 0; i < 500; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));
      for (int i = 0; i < 500; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
      sq.delete();
      for (int i = 0; i < 3; i++) begin
         d = 16'($urandom);
         sq.push_back(int'(d[9:0]));
         cycle(1'b0, 1'b0, 1'b1, d);
      end
      for (int i = 0; i < 100; i++) begin
         d = 16'($urandom);
         chk("swap_dout", 32'(fq.ptr_dout_s), sq.pop_front());
         sq.push_back(int'(d[9:0]));
         cycle(1'b0, 1'b1, 1'b1, d);
         chk("swap_count", 32'(fq.FQ_count), 3);
      end

      // Mid-run reset at count 200.
      for (int i = 0; i < 197; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));
      chk("pre_rst_count", 32'(fq.FQ_count), 200);
      cycle(1'b1, 1'b1, 1'b1, 16'h0);
      chk("rst_act", 32'(fq.FQ_act), 0);
      chk("rst_count", 32'(fq.FQ_count), 0);
      for (int i = 0; i < 512; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
      chk("reinit_count", 32'(fq.FQ_count), 512);
      chk("reinit_dout", 32'(fq.ptr_dout_s), 0);
      cycle(1'b0, 1'b0, 1'b1, 16'h0123);
      chk("full_push_count", 32'(fq.FQ_count), 512);
      chk("full_push_dout", 32'(fq.ptr_dout_s), 0);

      // Randomized traffic against the reference queue.
      pr_tab[0] = 70;
      pr_tab[1] = 30;
      pr_tab[2] = 75;
      pr_tab[3] = 50;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 1999) == 0,
                  $urandom_range(0, 99) < pr_tab[b],
                  $urandom_range(0, 99) < (100 - pr_tab[b]),
                  16'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/free_ptr_queue.md
# free_ptr_queue

Free-cell pointer queue for the shared-buffer switch core. After reset it loads itself with every buffer cell pointer (0..511). It then hands out free pointers to the ingress writer and takes back pointers released by the egress reader. It sits beside the 128-bit cell data RAM (4 words per cell) and the per-cell multicast-count RAM, whose address spaces it indexes.

## Interface
- PTR_NUM, 512: number of cell pointers managed; also the queue depth.
- PTR_W, 10: stored and returned pointer width.
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ptr_din  input  16  pointer returned to the queue; only [9:0] is stored, [15:10] is ignored.
- FQ_wr  input  1  push ptr_din this cycle.
- FQ_rd  input  1  pop the head pointer this cycle.
- ptr_dout_s  output  10  show-ahead head pointer; valid while ptr_fifo_empty=0.
- ptr_fifo_empty  output  1  high when FQ_count==0.
- FQ_act  output  1  high once initialisation is complete; stays high until the next rst.
- FQ_count  output  10  number of pointers currently queued, 0..512.

## Operation
- Storage is a circular buffer of PTR_NUM × PTR_W entries with a 9-bit head index, a 9-bit tail index and a 10-bit count.
- Both indices wrap modulo 512.
- States are INIT and RUN.
- **INIT** (entered on rst):
  - One entry is written per clock: pointer value k goes to slot k, for k = 0..511.
  - Tail advances and count increments on each write.
  - FQ_rd and FQ_wr are ignored.
- **INIT → RUN** on the edge that writes pointer 511. At that edge: count=512, tail wraps to 0, FQ_act=1.
- **RUN**:
  - FQ_rd with count>0: head advances and count decrements.
  - FQ_wr with count<512: ptr_din[9:0] is written at tail, tail advances, count increments.
  - FQ_rd and FQ_wr together with 0<count≤512: both are performed and the count is unchanged.
  - Pop when count==0: ignored; head and count unchanged. If FQ_wr is also high, only the push happens (count becomes 1).
  - Push when count==512 with no pop: ignored, and the pointer is dropped.
  - Duplicate or out-of-range pointers are not checked. Callers must only return pointers they were given.
- ptr_dout_s = mem[head], driven combinationally from the current head. A consumer samples it in the same cycle it raises FQ_rd.
- When count==0, ptr_dout_s is undefined (it holds the stale slot contents).
- ptr_fifo_empty = (count==0).
- FQ_count is the registered count value.

## Timing
- Reset values (while rst is high and on the first edge after): FQ_act=0, FQ_count=0, ptr_fifo_empty=1, head=0, tail=0. ptr_dout_s shows mem[0] and may be X before the first load.
- rst asserted mid-operation, in either state, abandons all contents and restarts INIT on the next edge.
- INIT length: the first edge with rst low writes pointer 0. After 512 edges, FQ_act=1 and FQ_count=512.
- ptr_fifo_empty goes low after the first INIT write. During INIT, FQ_count reads 1..512.
- Pop latency: the head value is available combinationally. After a pop edge, ptr_dout_s shows the next entry in the same cycle the new count appears.
- Push latency: a pointer pushed at edge N into an empty queue appears on ptr_dout_s with ptr_fifo_empty=0 after edge N, i.e. one-cycle write-to-read.
- Count updates by at most ±1 per edge and never leaves 0..512.

## Test plan
- Reset then idle 512 cycles:
  - FQ_act rises exactly on the 512th edge after rst deasserts.
  - FQ_count=512, ptr_fifo_empty=0, ptr_dout_s=0.
- Pop 5 consecutive cycles after INIT → ptr_dout_s sampled per cycle is 0,1,2,3,4; FQ_count ends at 507.
- Pop all 512 pointers → values come out 0..511 in order; final FQ_count=0 and ptr_fifo_empty=1. An extra FQ_rd leaves the count at 0.
- From empty, push ptr_din=16'hFC07 → next cycle FQ_count=1, ptr_dout_s=10'h007, empty=0.
- Push and pop simultaneously for 100 cycles at count=3:
  - FQ_count stays 3.
  - Output order is the 3 original entries, then the pushed values in FIFO order.
  - Tail and head wrap past 511 correctly.
- Assert rst for 1 cycle at count=200 mid-RUN → FQ_act=0, FQ_count=0, then INIT repeats and gives FQ_count=512 and ptr_dout_s=0 after 512 edges. A push at full (count=512) is ignored.
